srg_rx_deser: RTL and testbench
===============================

// Module: srg_rx_deser
// PURPOSE
//   Serial-to-parallel receiver placed directly downstream of the srg_4 PISO shift register.
//   Watches the same sh_ld strobe that drives srg_4 (0 = load, 1 = shift) and samples srg_4's serial y output.
//   Re-assembles each shifted frame into a WIDTH-bit word and presents it on a valid/ready output port.
//   Flags aborted frames and words lost to back-pressure.
// PARAMETERS
//   WIDTH      8   bits per frame; must match the srg_4 load width
//   MSB_FIRST  1   1: first sampled bit -> out_data[WIDTH-1]; 0: first sampled bit -> out_data[0]
// PORTS
//   clk        in   1      single clock, rising edge; same clock as srg_4
//   rst        in   1      synchronous, active-high reset
//   serial_in  in   1      srg_4 y output
//   sh_ld      in   1      srg_4 mode strobe: 0 = load, 1 = shift
//   out_data   out  WIDTH  assembled word; stable while out_valid=1
//   out_valid  out  1      word available
//   out_ready  in   1      consumer accepts the word on an edge where out_valid & out_ready
//   frame_err  out  1      one-cycle pulse: frame aborted before WIDTH bits were sampled
//   overflow   out  1      sticky: a completed word was dropped; cleared only by rst
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, bit count=0, shift reg=0.
//     Outputs: out_data=0, out_valid=0, frame_err=0, overflow=0.
//     rst wins over every other event, including mid-frame; the partial frame is discarded silently (no frame_err).
//   FSM states: IDLE, ARMED, SHIFT, DONE.
//     IDLE  : sh_ld=0 -> ARMED; otherwise stay (shift cycles with no prior load are ignored).
//     ARMED : sh_ld=0 -> stay (load held).
//             sh_ld=1 -> sample serial_in as bit 0, cnt=1, go to SHIFT.
//     SHIFT : sh_ld=1 -> sample serial_in, cnt+1; when cnt reaches WIDTH, the word is complete -> DONE.
//             sh_ld=0 with cnt<WIDTH -> frame_err=1 for one cycle, discard bits, go to ARMED (this load starts a new frame).
//     DONE  : sh_ld=1 -> ignore extra shift cycles (srg_4 shifts out fill bits).
//             sh_ld=0 -> ARMED.
//   Sampling: one bit per rising edge with sh_ld=1, including the first shift edge after a load.
//     That first sample is srg_4's first output bit.
//   Counter: $clog2(WIDTH+1) bits; never exceeds WIDTH; no wrap.
//   Completion latency: out_valid=1 is visible after the edge that samples bit WIDTH-1.
//     A load-to-valid frame therefore takes WIDTH shift edges.
//   Output register (single entry), on a completion edge:
//     out_valid=0, or out_valid & out_ready -> load new word, out_valid=1.
//     out_valid & !out_ready -> drop new word, overflow=1; out_data and out_valid unchanged.
//   Without completion: out_valid & out_ready -> out_valid=0; out_data holds its last value.
//   Simultaneous handshake + completion: the new word replaces the accepted one with no bubble.
// CONFIGURATION
//   SRG_RX_PARITY_EN defined:
//     adds port  parity  out  1  = ^out_data (even parity: 1 when out_data has an odd number of ones).
//     parity is registered alongside out_data, updates on the same edge, resets to 0.
//   SRG_RX_PARITY_EN undefined: the parity port and its logic do not exist; all other behaviour is identical.
// TESTING
//   T1 load X=8'hFF, hold sh_ld=1 for 8 edges (MSB_FIRST=1, out_ready=1)
//      -> out_valid=1 after 8th edge, out_data=8'hFF; extra shift edges produce no second valid.
//   T2 load X=8'hAA, shift 8 edges -> out_data=8'hAA.
//      With MSB_FIRST=0 the same stream gives out_data=8'h55.
//   T3 load, shift 3 edges, drop sh_ld to 0 -> frame_err pulses exactly 1 cycle, no out_valid.
//      A following full 8'hFF frame is then received correctly.
//   T4 out_ready=0; frame 8'hFF then frame 8'hAA
//      -> out_data stays 8'hFF, overflow=1 and stays 1 until rst.
//   T5 rst=1 at 4th shift edge of 8'hAA, then a fresh load of 8'h0F + 8 shifts
//      -> out_data=8'h0F, frame_err never pulses.
//   T6 (SRG_RX_PARITY_EN) frames 8'hAA then 8'hAB -> parity=0 then parity=1.

Source files
------------

// File: rtl/srg_rx_deser_if.sv
// Output stream of srg_rx_deser: one assembled word with a valid/ready handshake.
//   out_data   assembled word, stable while out_valid=1
//   out_valid  word available
//   out_ready  consumer accepts the word on an edge where out_valid & out_ready
// master: the deserialiser (drives data/valid); slave: the consumer (drives ready).
interface srg_rx_deser_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/srg_rx_deser.sv
// Serial-to-parallel receiver for the srg_4 PISO shift register.
// Watches srg_4's sh_ld strobe (0 = load, 1 = shift) and samples its serial y output once per
// shift edge. Each WIDTH-bit frame is presented on a single-entry valid/ready output register.
//
// Ports:
//   clk        rising-edge clock shared with srg_4
//   rst        synchronous active-high reset
//   serial_in  srg_4 y output
//   sh_ld      srg_4 mode strobe: 0 = load, 1 = shift
//   out        srg_rx_deser_if.master: out_data / out_valid / out_ready
//   frame_err  one-cycle pulse: a frame was cut short by a load
//   overflow   sticky: a completed word was dropped because the output was full
//   parity     (only with SRG_RX_PARITY_EN) even parity of out_data, registered with it
//
// Optional feature macro: SRG_RX_PARITY_EN.
// WIDTH must be at least 2.
module srg_rx_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 sh_ld,
  srg_rx_deser_if.master       out,
`ifdef SRG_RX_PARITY_EN
  output logic                 parity,
`endif
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovf_q, ovf_d;
  logic             complete;

  // Insert one sampled bit; the first bit of a frame ends up at the MSB or the LSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  // Frame FSM and shift register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    ferr_d   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Shift cycles without a preceding load are not a frame.
        if (!sh_ld) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (sh_ld) begin
          sr_d    = shift_in('0, serial_in);
          cnt_d   = CntW'(1);
          state_d = StShift;
        end else begin
          cnt_d = '0;
        end
      end
      StShift: begin
        if (sh_ld) begin
          sr_d  = shift_in(sr_q, serial_in);
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            complete = 1'b1;
            state_d  = StDone;
          end
        end else begin
          // A load mid-frame aborts it and is itself the start of the next frame.
          ferr_d  = 1'b1;
          cnt_d   = '0;
          state_d = StArmed;
        end
      end
      StDone: begin
        // Extra shift edges carry srg_4 fill bits and are ignored.
        if (!sh_ld) begin
          state_d = StArmed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Single-entry output register; a full, unaccepted register drops the new word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (complete) begin
      if (!valid_q || out.out_ready) begin
        data_d  = sr_d;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && out.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SRG_RX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity = parity_q;
`endif

  assign out.out_data  = data_q;
  assign out.out_valid = valid_q;
  assign frame_err     = ferr_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_srg_rx_deser.sv
// Bench for srg_rx_deser: an MSB-first and an LSB-first instance share the same inputs and are
// compared every cycle against a queue-based reference model of frames, handshake and flags.
module tb_srg_rx_deser;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b0;
  logic sh_ld = 1'b1;
  logic rdy = 1'b1;
  logic ferr_m, ovf_m, ferr_l, ovf_l;
`ifdef SRG_RX_PARITY_EN
  logic par_m, par_l;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  srg_rx_deser_if #(.WIDTH(W)) bus_m ();
  srg_rx_deser_if #(.WIDTH(W)) bus_l ();
  assign bus_m.out_ready = rdy;
  assign bus_l.out_ready = rdy;

  srg_rx_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .sh_ld     (sh_ld),
    .out       (bus_m),
`ifdef SRG_RX_PARITY_EN
    .parity    (par_m),
`endif
    .frame_err (ferr_m),
    .overflow  (ovf_m)
  );

  srg_rx_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .sh_ld     (sh_ld),
    .out       (bus_l),
`ifdef SRG_RX_PARITY_EN
    .parity    (par_l),
`endif
    .frame_err (ferr_l),
    .overflow  (ovf_l)
  );

  // Reference model state.
  bit         bits[$];
  bit         in_frame;
  bit         e_valid_m, e_valid_l, e_ferr, e_ovf_m, e_ovf_l;
  bit [W-1:0] e_data_m, e_data_l;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_out(input bit done, input bit [W-1:0] word, inout bit v,
                           inout bit [W-1:0] d, inout bit ovf);
    if (done) begin
      if (!v || rdy) begin
        v = 1'b1;
        d = word;
      end else begin
        ovf = 1'b1;
      end
    end else if (v && rdy) begin
      v = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit         done;
    bit [W-1:0] wm, wl;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (rst) begin
      bits.delete();
      in_frame  = 1'b0;
      e_valid_m = 1'b0;
      e_valid_l = 1'b0;
      e_data_m  = '0;
      e_data_l  = '0;
      e_ferr    = 1'b0;
      e_ovf_m   = 1'b0;
      e_ovf_l   = 1'b0;
      return;
    end
    e_ferr = 1'b0;
    if (!sh_ld) begin
      // Any load starts a fresh frame; partially collected bits mean an aborted one.
      if (in_frame && bits.size() > 0) e_ferr = 1'b1;
      bits.delete();
      in_frame = 1'b1;
    end else if (in_frame) begin
      bits.push_back(serial_in);
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits[i];
          wl[i]     = bits[i];
        end
        done     = 1'b1;
        in_frame = 1'b0;
        bits.delete();
      end
    end
    model_out(done, wm, e_valid_m, e_data_m, e_ovf_m);
    model_out(done, wl, e_valid_l, e_data_l, e_ovf_l);
  endtask

  task automatic step(input bit r, input bit sh, input bit sin, input bit rd);
    @(negedge clk);
    rst       = r;
    sh_ld     = sh;
    serial_in = sin;
    rdy       = rd;
    @(posedge clk);
    model_edge();
    #1;
    check("valid_msb", 32'(bus_m.out_valid), 32'(e_valid_m));
    check("data_msb", 32'(bus_m.out_data), 32'(e_data_m));
    check("valid_lsb", 32'(bus_l.out_valid), 32'(e_valid_l));
    check("data_lsb", 32'(bus_l.out_data), 32'(e_data_l));
    check("frame_err", {30'd0, ferr_l, ferr_m}, {30'd0, e_ferr, e_ferr});
    check("overflow_msb", 32'(ovf_m), 32'(e_ovf_m));
    check("overflow_lsb", 32'(ovf_l), 32'(e_ovf_l));
`ifdef SRG_RX_PARITY_EN
    check("parity_msb", 32'(par_m), 32'(^e_data_m));
    check("parity_lsb", 32'(par_l), 32'(^e_data_l));
`endif
  endtask

  // One load cycle followed by nshift shift edges carrying val MSB-first, then zero fill.
  task automatic send_frame(input bit [W-1:0] val, input int nshift, input bit rd);
    step(1'b0, 1'b0, 1'b0, rd);
    for (int i = 0; i < nshift; i++) begin
      step(1'b0, 1'b1, (i < W) ? val[W-1-i] : 1'b0, rd);
    end
  endtask

  initial begin
    bit [W-1:0] v;
    int         seen_valid;

    // Reset state
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_valid", 32'(bus_m.out_valid), 32'd0);
    check("reset_overflow", 32'(ovf_m), 32'd0);

    // T1: 8'hFF, valid after the 8th shift edge, extra shifts give no second word
    send_frame(8'hFF, 7, 1'b1);
    check("t1_not_yet_valid", 32'(bus_m.out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t1_valid", 32'(bus_m.out_valid), 32'd1);
    check("t1_data", 32'(bus_m.out_data), 32'hFF);
    seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      if (bus_m.out_valid) seen_valid++;
    end
    check("t1_no_second_valid", 32'(seen_valid), 32'd0);

    // T2: 8'hAA, MSB-first gives AA and LSB-first gives 55
    send_frame(8'hAA, 8, 1'b1);
    check("t2_msb", 32'(bus_m.out_data), 32'hAA);
    check("t2_lsb", 32'(bus_l.out_data), 32'h55);

    // T3: aborted frame then a clean 8'hFF frame
    step(1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'hAA, 3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_ferr_pulse", 32'(ferr_m), 32'd1);
    check("t3_no_valid", 32'(bus_m.out_valid), 32'd0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t3_ferr_cleared", 32'(ferr_m), 32'd0);
    check("t3_data", 32'(bus_m.out_data), 32'hFF);

    // T4: back-pressure drops the second frame and sets sticky overflow
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 8, 1'b0);
    send_frame(8'hAA, 8, 1'b0);
    check("t4_data_kept", 32'(bus_m.out_data), 32'hFF);
    check("t4_overflow", 32'(ovf_m), 32'd1);
    send_frame(8'h0F, 8, 1'b1);
    check("t4_overflow_sticky", 32'(ovf_m), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t4_overflow_rst", 32'(ovf_m), 32'd0);

    // T5: reset on the 4th shift edge, then a fresh 8'h0F frame
    send_frame(8'hAA, 3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_ferr_on_rst", 32'(ferr_m), 32'd0);
    send_frame(8'h0F, 8, 1'b1);
    check("t5_ferr_silent", 32'(ferr_m), 32'd0);
    check("t5_data", 32'(bus_m.out_data), 32'h0F);

`ifdef SRG_RX_PARITY_EN
    // T6: parity follows the registered word
    send_frame(8'hAA, 8, 1'b1);
    check("t6_parity_aa", 32'(par_m), 32'd0);
    send_frame(8'hAB, 8, 1'b1);
    check("t6_parity_ab", 32'(par_m), 32'd1);
`endif

    // Randomized frames: variable load/shift lengths, random back-pressure, rare resets
    for (int seg = 0; seg < 300; seg++) begin
      int nload, nshift;
      if ($urandom_range(0, 19) == 0) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      nload  = $urandom_range(1, 3);
      nshift = ($urandom_range(0, 3) == 0) ? $urandom_range(0, W - 1) : $urandom_range(W, W + 4);
      for (int i = 0; i < nload; i++) begin
        step(1'b0, 1'b0, 1'($urandom), ($urandom_range(0, 9) < 7));
      end
      v = W'($urandom);
      for (int i = 0; i < nshift; i++) begin
        step(1'b0, 1'b1, (i < W) ? v[W-1-i] : 1'($urandom), ($urandom_range(0, 9) < 7));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
